// File: rtl/asteroid_timing_core.sv
// Timing and motion core for the dino/asteroid game: pixel-rate enable, run-animation
// frame select, and wrapping x/y offsets for three asteroid sprites.
module asteroid_timing_core #(
  parameter int DIV        = 4,
  parameter int ANIM_TICKS = 2500000,
  parameter int STEP_TICKS = 250000,
  parameter int X_WRAP     = 640,
  parameter int Y_WRAP     = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt,
  input  logic        restart,
  input  logic [2:0]  asteroid_on,
  output logic        pix_ce,
  output logic        runner,
  output logic [29:0] xmov,
  output logic [29:0] ymov
);

  localparam int DW = (DIV > 1)        ? $clog2(DIV)        : 1;
  localparam int AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  logic [DW-1:0] div_cnt;
  logic [AW-1:0] anim_cnt;
  logic [SW-1:0] step_cnt;
  logic          step_p0;

  // Sum is formed in 11 bits so the pre-wrap value cannot overflow; one
  // conditional subtract suffices because the increment is below the modulus.
  function automatic logic [9:0] wrap_add(input logic [9:0]  v,
                                          input logic [1:0]  inc,
                                          input logic [10:0] modulus);
    logic [10:0] sum;
    sum = {1'b0, v} + {9'd0, inc};
    if (sum >= modulus) sum = sum - modulus;
    return sum[9:0];
  endfunction

  // Stage: board clock -> pixel enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else if (div_cnt == DW'(DIV - 1)) begin
      div_cnt <= '0;
      pix_ce  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
      pix_ce  <= 1'b0;
    end
  end

  // Stage: pixel enable -> animation frame and motion step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_cnt <= '0;
      runner   <= 1'b0;
    end else if (pix_ce) begin
      if (anim_cnt == AW'(ANIM_TICKS - 1)) begin
        anim_cnt <= '0;
        runner   <= ~runner;
      end else begin
        anim_cnt <= anim_cnt + AW'(1);
      end
    end
  end

  assign step_p0 = pix_ce && !halt && !restart && (step_cnt == SW'(STEP_TICKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt <= '0;
    end else if (restart) begin
      step_cnt <= '0;
    end else if (!halt && pix_ce) begin
      if (step_cnt == SW'(STEP_TICKS - 1)) step_cnt <= '0;
      else                                 step_cnt <= step_cnt + SW'(1);
    end
  end

  // Stage: step -> per-asteroid offsets (channel k moves down by k+1 per step)
  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic [9:0] x_q;
    logic [9:0] y_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        x_q <= '0;
        y_q <= '0;
      end else if (restart || !asteroid_on[k]) begin
        x_q <= '0;
        y_q <= '0;
      end else if (!halt && step_p0) begin
        x_q <= wrap_add(x_q, 2'd1, 11'(X_WRAP));
        y_q <= wrap_add(y_q, 2'(k + 1), 11'(Y_WRAP));
      end
    end

    assign xmov[10*k +: 10] = x_q;
    assign ymov[10*k +: 10] = y_q;
  end

endmodule

// File: tb/tb_asteroid_timing_core.sv
// Directed bench for asteroid_timing_core with small parameters (DIV=4, ANIM=3, STEP=2, 8x6 wrap).
module tb_asteroid_timing_core;

  logic        clk;
  logic        reset_n;
  logic        halt;
  logic        restart;
  logic [2:0]  asteroid_on;
  logic        pix_ce;
  logic        runner;
  logic [29:0] xmov;
  logic [29:0] ymov;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int edge_no   = 0;

  asteroid_timing_core #(
    .DIV(4), .ANIM_TICKS(3), .STEP_TICKS(2), .X_WRAP(8), .Y_WRAP(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .restart(restart),
    .asteroid_on(asteroid_on), .pix_ce(pix_ce), .runner(runner),
    .xmov(xmov), .ymov(ymov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to absolute edge number (counted from reset release), sampling 1ns after.
  task automatic run_to(input int target);
    while (edge_no < target) begin
      @(posedge clk);
      #1;
      edge_no++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (pix_ce !== 1'b0) $display("FAIL reset_pix_ce: got %b want 0", pix_ce);
    else pass_cnt++;
    total_cnt++;
    if (runner !== 1'b0) $display("FAIL reset_runner: got %b want 0", runner);
    else pass_cnt++;
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL reset_xmov: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== 30'd0) $display("FAIL reset_ymov: got %h want 0", ymov);
    else pass_cnt++;
  endtask

  task automatic test_divider();
    logic exp_ce;
    logic exp_run;
    @(negedge clk);
    reset_n = 1'b1;
    edge_no = 0;
    for (int e = 1; e <= 16; e++) begin
      run_to(e);
      exp_ce  = (e % 4 == 0);
      exp_run = (e >= 13);
      total_cnt++;
      if (pix_ce !== exp_ce) $display("FAIL pix_ce_e%0d: got %b want %b", e, pix_ce, exp_ce);
      else pass_cnt++;
      total_cnt++;
      if (runner !== exp_run) $display("FAIL runner_e%0d: got %b want %b", e, runner, exp_run);
      else pass_cnt++;
    end
  endtask

  task automatic test_motion();
    run_to(17);
    total_cnt++;
    if (xmov !== {10'd2, 10'd2, 10'd2}) $display("FAIL two_steps_x: got %h want %h", xmov, {10'd2, 10'd2, 10'd2});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd4, 10'd2}) $display("FAIL two_steps_y: got %h want %h", ymov, {10'd0, 10'd4, 10'd2});
    else pass_cnt++;
    run_to(24);
    total_cnt++;
    if (runner !== 1'b1) $display("FAIL runner_before_6th: got %b want 1", runner);
    else pass_cnt++;
    run_to(25);
    total_cnt++;
    if (runner !== 1'b0) $display("FAIL runner_after_6th: got %b want 0", runner);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    run_to(49);
    total_cnt++;
    if (xmov !== {10'd6, 10'd6, 10'd6}) $display("FAIL step6_x: got %h want %h", xmov, {10'd6, 10'd6, 10'd6});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd0, 10'd0}) $display("FAIL step6_y: got %h want 0", ymov);
    else pass_cnt++;
    run_to(57);
    total_cnt++;
    if (xmov !== {10'd7, 10'd7, 10'd7}) $display("FAIL step7_x: got %h want %h", xmov, {10'd7, 10'd7, 10'd7});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd3, 10'd2, 10'd1}) $display("FAIL step7_y: got %h want %h", ymov, {10'd3, 10'd2, 10'd1});
    else pass_cnt++;
    run_to(65);
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL step8_x_wrap: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd4, 10'd2}) $display("FAIL step8_y_wrap: got %h want %h", ymov, {10'd0, 10'd4, 10'd2});
    else pass_cnt++;
  endtask

  task automatic test_halt();
    run_to(69);
    halt = 1'b1;
    run_to(73);
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL halt_first_x: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd4, 10'd2}) $display("FAIL halt_first_y: got %h want %h", ymov, {10'd0, 10'd4, 10'd2});
    else pass_cnt++;
    total_cnt++;
    if (runner !== 1'b0) $display("FAIL halt_runner_a: got %b want 0", runner);
    else pass_cnt++;
    run_to(109);
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL halt_last_x: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd4, 10'd2}) $display("FAIL halt_last_y: got %h want %h", ymov, {10'd0, 10'd4, 10'd2});
    else pass_cnt++;
    total_cnt++;
    if (runner !== 1'b1) $display("FAIL halt_runner_b: got %b want 1", runner);
    else pass_cnt++;
    halt = 1'b0;
    run_to(112);
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL resume_early_x: got %h want 0", xmov);
    else pass_cnt++;
    run_to(113);
    total_cnt++;
    if (xmov !== {10'd1, 10'd1, 10'd1}) $display("FAIL resume_x: got %h want %h", xmov, {10'd1, 10'd1, 10'd1});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd3, 10'd0, 10'd3}) $display("FAIL resume_y: got %h want %h", ymov, {10'd3, 10'd0, 10'd3});
    else pass_cnt++;
  endtask

  task automatic test_restart();
    run_to(117);
    halt    = 1'b1;
    restart = 1'b1;
    run_to(118);
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL restart_x: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== 30'd0) $display("FAIL restart_y: got %h want 0", ymov);
    else pass_cnt++;
    halt    = 1'b0;
    restart = 1'b0;
    run_to(124);
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL restart_wait_x: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== 30'd0) $display("FAIL restart_wait_y: got %h want 0", ymov);
    else pass_cnt++;
    run_to(125);
    total_cnt++;
    if (xmov !== {10'd1, 10'd1, 10'd1}) $display("FAIL restart_step_x: got %h want %h", xmov, {10'd1, 10'd1, 10'd1});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd3, 10'd2, 10'd1}) $display("FAIL restart_step_y: got %h want %h", ymov, {10'd3, 10'd2, 10'd1});
    else pass_cnt++;
  endtask

  task automatic test_mask();
    asteroid_on = 3'b010;
    run_to(126);
    total_cnt++;
    if (xmov !== {10'd0, 10'd1, 10'd0}) $display("FAIL park_x: got %h want %h", xmov, {10'd0, 10'd1, 10'd0});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd2, 10'd0}) $display("FAIL park_y: got %h want %h", ymov, {10'd0, 10'd2, 10'd0});
    else pass_cnt++;
    run_to(133);
    total_cnt++;
    if (xmov !== {10'd0, 10'd2, 10'd0}) $display("FAIL mask_step_x: got %h want %h", xmov, {10'd0, 10'd2, 10'd0});
    else pass_cnt++;
    total_cnt++;
    if (ymov !== {10'd0, 10'd4, 10'd0}) $display("FAIL mask_step_y: got %h want %h", ymov, {10'd0, 10'd4, 10'd0});
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    total_cnt++;
    if (runner !== 1'b1) $display("FAIL pre_reset_runner: got %b want 1", runner);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (runner !== 1'b0) $display("FAIL async_runner: got %b want 0", runner);
    else pass_cnt++;
    total_cnt++;
    if (pix_ce !== 1'b0) $display("FAIL async_pix_ce: got %b want 0", pix_ce);
    else pass_cnt++;
    total_cnt++;
    if (xmov !== 30'd0) $display("FAIL async_xmov: got %h want 0", xmov);
    else pass_cnt++;
    total_cnt++;
    if (ymov !== 30'd0) $display("FAIL async_ymov: got %h want 0", ymov);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    halt        = 1'b0;
    restart     = 1'b0;
    asteroid_on = 3'b111;
    test_reset();
    test_divider();
    test_motion();
    test_wrap();
    test_halt();
    test_restart();
    test_mask();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/asteroid_timing_core.md
Name: asteroid_timing_core

Overview:
- Timing and motion core for the dino/asteroid VGA game.
- Derives a pixel-rate clock enable from the board clock and generates the two-frame dinosaur run-animation select.
- Drives the x/y offset counters of three asteroid sprites, which freeze on collision (halt) and rewind on game restart.
- Sits between the board clock and the sprite renderer, which adds the offsets to sprite base positions.

Parameters:
- DIV, 4: board clk cycles per pixel-enable pulse (100 MHz -> 25 MHz); must be >= 2.
- ANIM_TICKS, 2500000: pixel-enable pulses per runner toggle (10 Hz toggle at 25 MHz).
- STEP_TICKS, 250000: pixel-enable pulses per asteroid motion step (100 steps/s).
- X_WRAP, 640: x offset modulus.
- Y_WRAP, 480: y offset modulus.

Ports:
- clk, input, 1: board clock; the only clock; all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- halt, input, 1: collision freeze (synchronous).
- restart, input, 1: synchronous game restart; priority over halt.
- asteroid_on, input, 3: per-asteroid enable, bit k = asteroid k.
- pix_ce, output, 1: registered pixel-rate enable pulse.
- runner, output, 1: run-animation frame select (1 = frame 1, 0 = frame 2).
- xmov, output, 30: packed x offsets; asteroid k at bits [10k+9:10k].
- ymov, output, 30: packed y offsets; same packing.

Behaviour:
- Reset (reset_n low, asynchronous): all counters 0, pix_ce=0, runner=0, all xmov/ymov=0.
- Divider:
  - Counter runs 0..DIV-1, then wraps to 0.
  - pix_ce is registered: high for exactly one clk cycle when the counter wraps, giving one pulse every DIV cycles.
  - First pulse is on the DIV-th rising edge after reset release.
  - halt and restart have no effect on the divider.
- Animation:
  - Counts pix_ce pulses 0..ANIM_TICKS-1.
  - On the pulse where the count is ANIM_TICKS-1, the count goes to 0 and runner inverts.
  - Free-running; unaffected by halt and restart.
- Step timer:
  - Counts pix_ce pulses 0..STEP_TICKS-1.
  - step is asserted on the pix_ce pulse where the count is ANIM_TICKS-style terminal value STEP_TICKS-1; the count then wraps to 0.
  - While halt=1 and restart=0: the count holds.
  - restart=1 clears the count to 0 that cycle.
- Asteroid channel k (k=0,1,2), evaluated per clk in priority order:
  1. restart=1: x_k=0, y_k=0.
  2. asteroid_on[k]=0: x_k=0, y_k=0 (parked).
  3. halt=1: hold.
  4. step: x_k <= (x_k+1) mod X_WRAP; y_k <= (y_k+k+1) mod Y_WRAP.
  5. Otherwise: hold.
- Wrap arithmetic: compute in 11 bits. If the sum >= modulus, subtract the modulus. Outputs are always < modulus and never overflow 10 bits.
- Simultaneous restart and halt: restart wins; offsets and step count both zero.
- Releasing halt: motion resumes from the held values. The next step fires after the remaining held count, not a fresh STEP_TICKS.
- Reset mid-operation: immediate return to reset values, regardless of clk.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (DIV=4, ANIM_TICKS=3, STEP_TICKS=2, X_WRAP=8, Y_WRAP=6):
- Release reset, idle inputs (halt=0, restart=0, asteroid_on=3'b111) -> pix_ce pulses on edges 4, 8, 12, ..., each one cycle wide; runner toggles 0->1 at the 3rd pulse, 1->0 at the 6th.
- Run 4 pix_ce pulses -> 2 steps taken: x0=x1=x2=2; y0=2, y1=4, y2=0 (6 mod 6).
- Run 8 steps from zero -> x wraps to 0 for all channels; y0=2 (8 mod 6), y1=4 (16 mod 6), y2=0 (24 mod 6).
- Assert halt for 10 pix_ce pulses mid-motion -> xmov/ymov and runner-independent step count frozen; runner keeps toggling; releasing halt resumes stepping from the frozen values.
- Assert restart together with halt -> all xmov/ymov read 0 the next cycle; the first step after release occurs 2 pix_ce pulses later.
- asteroid_on=3'b010 -> channels 0 and 2 stay 0 while channel 1 steps normally. Pulse reset_n low mid-cycle, asynchronously -> all outputs 0 immediately.
